// File: rtl/serial_sub_datapath.sv
// serial_sub_datapath
// Bit-serial 16-bit subtractor: Diff = (A - B) mod 2^16, Borrow = (A < B).
// B is loaded from the switches by Load_B; Run samples the minuend A from the
// switches and starts a 16-cycle LSB-first subtraction.
//
// Start/done handshake: the operation request is the level of Run_h (~Run)
// sampled on a rising edge while IDLE. Busy is high for exactly the 16 edges
// that process bits. Done is then held until Run_h is sampled low, so one
// press of Run (however long) yields exactly one result. Diff_out/Borrow_out
// change only on the edge that enters DONE.
module serial_sub_datapath (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load_B,
    input  logic        Run,
    input  logic [15:0] SW,
    output logic [15:0] B_out,
    output logic [15:0] Diff_out,
    output logic        Borrow_out,
    output logic        Busy,
    output logic        Done,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;

    // Active-high versions of the push buttons (already debounced and synchronous)
    logic        run_h;
    logic        loadb_h;

    // Datapath registers
    logic [15:0] a_sh;      // minuend, shifted right one bit per SHIFT edge
    logic [15:0] b_reg;     // user-visible subtrahend
    logic [15:0] b_sh;      // working copy of B consumed during SHIFT
    logic [15:0] diff_sh;   // difference being assembled, MSB-in
    logic [15:0] diff_reg;  // last completed difference
    logic        borrow_reg;
    logic        br;        // running borrow between bit positions
    logic [3:0]  cnt;       // bit index of the bit processed on the next SHIFT edge

    // One-bit full subtractor on the current LSBs
    logic        bit_a;
    logic        bit_b;
    logic        bit_d;
    logic        br_next;
    logic [15:0] diff_next;
    logic        last_bit;

    // Button polarity inversion
    always_comb begin
        run_h   = ~Run;
        loadb_h = ~Load_B;
    end

    // Full-subtractor slice and next value of the difference shift register
    always_comb begin
        bit_a     = a_sh[0];
        bit_b     = b_sh[0];
        bit_d     = bit_a ^ bit_b ^ br;
        br_next   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
        diff_next = {bit_d, diff_sh[15:1]};
        last_bit  = (cnt == 4'd15);
    end

    // Control FSM and all datapath state; results are written only on the final bit
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            a_sh       <= 16'h0000;
            b_reg      <= 16'h0000;
            b_sh       <= 16'h0000;
            diff_sh    <= 16'h0000;
            diff_reg   <= 16'h0000;
            borrow_reg <= 1'b0;
            br         <= 1'b0;
            cnt        <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_h) begin
                        // Run has priority: a simultaneous Load_B is dropped,
                        // so the subtraction uses the B already held.
                        a_sh  <= SW;
                        b_sh  <= b_reg;
                        br    <= 1'b0;
                        cnt   <= 4'd0;
                        state <= SHIFT;
                    end else if (loadb_h) begin
                        b_reg <= SW;
                    end
                end

                SHIFT: begin
                    // Buttons are ignored here; B and the outputs stay frozen.
                    diff_sh <= diff_next;
                    a_sh    <= {1'b0, a_sh[15:1]};
                    b_sh    <= {1'b0, b_sh[15:1]};
                    br      <= br_next;
                    cnt     <= cnt + 4'd1;  // wraps to 0 after the last bit
                    if (last_bit) begin
                        diff_reg   <= diff_next;
                        borrow_reg <= br_next;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    if (loadb_h) begin
                        b_reg <= SW;
                    end
                    // Stay here while Run is held so a long press cannot restart.
                    if (!run_h) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status decode straight from the state; Busy and Done are mutually exclusive
    always_comb begin
        Busy       = (state == SHIFT);
        Done       = (state == DONE);
        state_dbg  = state;
        B_out      = b_reg;
        Diff_out   = diff_reg;
        Borrow_out = borrow_reg;
    end

endmodule

// File: tb/tb_serial_sub_datapath.sv
// Testbench for serial_sub_datapath: directed corner cases plus random
// operand pairs, with expected results queued when each operation starts.
module tb_serial_sub_datapath;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Load_B;
  logic        Run;
  logic [15:0] SW;
  logic [15:0] B_out;
  logic [15:0] Diff_out;
  logic        Borrow_out;
  logic        Busy;
  logic        Done;
  logic [1:0]  state_dbg;

  serial_sub_datapath dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Load_B     (Load_B),
    .Run        (Run),
    .SW         (SW),
    .B_out      (B_out),
    .Diff_out   (Diff_out),
    .Borrow_out (Borrow_out),
    .Busy       (Busy),
    .Done       (Done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q[$];      // {borrow, diff}
  logic [15:0] b_model;
  logic [15:0] last_diff;
  logic        last_borrow;

  // ---------------- driver tasks ----------------
  task automatic load_b(input logic [15:0] v);
    @(negedge Clk);
    SW     = v;
    Load_B = 1'b0;
    @(negedge Clk);
    Load_B = 1'b1;
    b_model = v;
  endtask

  // Press Run for one edge; returns on the negedge after the start edge.
  task automatic start_op(input logic [15:0] a);
    logic [15:0] d;
    @(negedge Clk);
    SW  = a;
    Run = 1'b0;
    d   = a - b_model;
    exp_q.push_back({(a < b_model), d});
    @(negedge Clk);
    Run = 1'b1;
  endtask

  // Step negedges until Done, counting Busy cycles and watching outputs hold.
  task automatic wait_done(output int busy_cycles, output bit timed_out, output bit held_ok);
    busy_cycles = 0;
    timed_out   = 1'b1;
    held_ok     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        timed_out = 1'b0;
        break;
      end
      if (Busy) begin
        busy_cycles++;
        if (Diff_out !== last_diff || Borrow_out !== last_borrow) held_ok = 1'b0;
      end
      @(negedge Clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    Reset  = 1'b0;
    Run    = 1'b1;
    Load_B = 1'b1;
    SW     = 16'h0000;
    #12;
    n_checks++;
    if ({B_out, Diff_out, Borrow_out, Busy, Done} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got B=%h D=%h br=%b busy=%b done=%b, want all zero",
               B_out, Diff_out, Borrow_out, Busy, Done);
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    @(negedge Clk);
    Reset = 1'b1;
    b_model     = 16'h0000;
    last_diff   = 16'h0000;
    last_borrow = 1'b0;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_autostart: busy=%b done=%b want 0 0", Busy, Done);
    end
  endtask

  task automatic test_basic;
    int busy_c; bit to; bit held; logic [16:0] e;
    load_b(16'h0034);
    n_checks++;
    if (B_out !== 16'h0034) begin
      n_fail++;
      $display("FAIL basic_load: B_out=%h want 0034", B_out);
    end
    start_op(16'h1234);
    wait_done(busy_c, to, held);
    e = exp_q.pop_front();
    n_checks++;
    if (to || {Borrow_out, Diff_out} !== e || e !== {1'b0, 16'h1200}) begin
      n_fail++;
      $display("FAIL basic_result: timeout=%b got br=%b D=%h want br=0 D=1200", to, Borrow_out, Diff_out);
    end
    n_checks++;
    if (busy_c != 16 || !held) begin
      n_fail++;
      $display("FAIL basic_latency: busy=%0d held=%b want 16 1", busy_c, held);
    end
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_done_excl: busy=%b done=%b", Busy, Done);
    end
    last_diff = e[15:0]; last_borrow = e[16];
    // Load B while in DONE; result must stay put.
    SW     = 16'hBEEF;
    Load_B = 1'b0;
    @(negedge Clk);
    Load_B = 1'b1;
    b_model = 16'hBEEF;
    n_checks++;
    if (B_out !== 16'hBEEF || Diff_out !== 16'h1200 || Done !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_load: B=%h D=%h done=%b busy=%b want BEEF 1200 0 0", B_out, Diff_out, Done, Busy);
    end
  endtask

  task automatic test_boundaries;
    logic [15:0] bt[4] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
    logic [15:0] at[4] = '{16'h0000, 16'h8000, 16'h0000, 16'hFFFF};
    logic [16:0] want[4] = '{{1'b1, 16'hFFFF}, {1'b0, 16'h0000}, {1'b1, 16'h0001}, {1'b0, 16'hFFFF}};
    int busy_c; bit to; bit held; logic [16:0] e;
    for (int i = 0; i < 4; i++) begin
      load_b(bt[i]);
      start_op(at[i]);
      wait_done(busy_c, to, held);
      e = exp_q.pop_front();
      n_checks++;
      if (to || {Borrow_out, Diff_out} !== e || e !== want[i]) begin
        n_fail++;
        $display("FAIL boundary_%0d: timeout=%b got br=%b D=%h want br=%b D=%h",
                 i, to, Borrow_out, Diff_out, want[i][16], want[i][15:0]);
      end
      n_checks++;
      if (busy_c != 16 || !held) begin
        n_fail++;
        $display("FAIL boundary_%0d_latency: busy=%0d held=%b want 16 1", i, busy_c, held);
      end
      last_diff = e[15:0]; last_borrow = e[16];
    end
  endtask

  task automatic test_run_load_same_edge;
    int busy_c; bit to; bit held; logic [16:0] e;
    load_b(16'h0005);
    @(negedge Clk);
    SW     = 16'h0009;
    Run    = 1'b0;
    Load_B = 1'b0;
    exp_q.push_back({1'b0, 16'h0004});
    @(negedge Clk);
    Run    = 1'b1;
    Load_B = 1'b1;
    wait_done(busy_c, to, held);
    e = exp_q.pop_front();
    n_checks++;
    if (to || {Borrow_out, Diff_out} !== e || B_out !== 16'h0005) begin
      n_fail++;
      $display("FAIL run_wins: timeout=%b got br=%b D=%h B=%h want br=0 D=0004 B=0005",
               to, Borrow_out, Diff_out, B_out);
    end
    last_diff = e[15:0]; last_borrow = e[16];
  endtask

  task automatic test_load_during_shift;
    int busy_c; bit to; bit held; logic [16:0] e;
    load_b(16'h0001);
    start_op(16'h0010);
    repeat (3) @(negedge Clk);
    SW     = 16'h00FF;
    Load_B = 1'b0;
    Run    = 1'b0;
    @(negedge Clk);
    Load_B = 1'b1;
    Run    = 1'b1;
    wait_done(busy_c, to, held);
    e = exp_q.pop_front();
    n_checks++;
    if (to || {Borrow_out, Diff_out} !== e || e !== {1'b0, 16'h000F}) begin
      n_fail++;
      $display("FAIL shift_ignore_result: timeout=%b got br=%b D=%h want br=0 D=000F", to, Borrow_out, Diff_out);
    end
    n_checks++;
    if (B_out !== 16'h0001 || !held) begin
      n_fail++;
      $display("FAIL shift_ignore_b: B=%h held=%b want 0001 1", B_out, held);
    end
    last_diff = e[15:0]; last_borrow = e[16];
    @(negedge Clk);
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL shift_ignore_no_restart: busy=%b done=%b want 0 0", Busy, Done);
    end
  endtask

  task automatic test_run_held;
    int busy_c = 0; int done_c = 0; bit popped = 0; logic [16:0] e;
    load_b(16'h0100);
    @(negedge Clk);
    SW  = 16'h0300;
    Run = 1'b0;
    exp_q.push_back({1'b0, 16'h0200});
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Busy) busy_c++;
      if (Done) begin
        done_c++;
        if (!popped) begin
          popped = 1'b1;
          e = exp_q.pop_front();
          n_checks++;
          if ({Borrow_out, Diff_out} !== e) begin
            n_fail++;
            $display("FAIL held_result: got br=%b D=%h want br=%b D=%h", Borrow_out, Diff_out, e[16], e[15:0]);
          end
          last_diff = e[15:0]; last_borrow = e[16];
        end
      end
    end
    n_checks++;
    if (busy_c != 16 || done_c != 24 || Done !== 1'b1) begin
      n_fail++;
      $display("FAIL held_one_shot: busy=%0d done=%0d done_now=%b want 16 24 1", busy_c, done_c, Done);
    end
    Run = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL held_release: done=%b busy=%b state=%0d want 0 0 0", Done, Busy, state_dbg);
    end
  endtask

  task automatic test_reset_mid_shift;
    int busy_c = 0; bit to; bit held; logic [16:0] e;
    load_b(16'h0007);
    start_op(16'h0100);
    repeat (8) @(posedge Clk);
    #1 Reset = 1'b0;
    #1;
    n_checks++;
    if ({B_out, Diff_out, Borrow_out, Busy, Done} !== 35'd0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_abort: B=%h D=%h br=%b busy=%b done=%b state=%0d want all zero",
               B_out, Diff_out, Borrow_out, Busy, Done, state_dbg);
    end
    void'(exp_q.pop_back());
    b_model = 16'h0000; last_diff = 16'h0000; last_borrow = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Busy || Done) busy_c++;
    end
    n_checks++;
    if (busy_c != 0 || Diff_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_no_resume: active_cycles=%0d D=%h want 0 0000", busy_c, Diff_out);
    end
    load_b(16'h0003);
    start_op(16'h0005);
    wait_done(busy_c, to, held);
    e = exp_q.pop_front();
    n_checks++;
    if (to || {Borrow_out, Diff_out} !== e || busy_c != 16) begin
      n_fail++;
      $display("FAIL reset_recover: timeout=%b busy=%0d got br=%b D=%h want br=0 D=0002",
               to, busy_c, Borrow_out, Diff_out);
    end
    last_diff = e[15:0]; last_borrow = e[16];
  endtask

  task automatic test_random;
    int busy_c; bit to; bit held; logic [16:0] e; logic [15:0] a; logic [15:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 16'($urandom_range(0, 65535));
      a = 16'($urandom_range(0, 65535));
      load_b(b);
      n_checks++;
      if (B_out !== b) begin
        n_fail++;
        $display("FAIL rand_%0d_load: B=%h want %h", i, B_out, b);
      end
      start_op(a);
      wait_done(busy_c, to, held);
      e = exp_q.pop_front();
      n_checks++;
      if (to || {Borrow_out, Diff_out} !== e || busy_c != 16 || !held) begin
        n_fail++;
        $display("FAIL rand_%0d: A=%h B=%h timeout=%b busy=%0d held=%b got br=%b D=%h want br=%b D=%h",
                 i, a, b, to, busy_c, held, Borrow_out, Diff_out, e[16], e[15:0]);
      end
      last_diff = e[15:0]; last_borrow = e[16];
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_run_load_same_edge();
    test_load_during_shift();
    test_run_held();
    test_reset_mid_shift();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
